// File: rtl/mac_pipe_param.sv
// Pipelined multiply-accumulate: valid/ready operand beats, PIPE-deep multiplier, per-frame result register.
// Define MAC_SAT_EN to make accumulation saturate instead of wrapping modulo 2^ACC_W.
module mac_pipe_param #(
  parameter int A_W   = 64,
  parameter int B_W   = 64,
  parameter int ACC_W = 128,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_last,
  output logic [ACC_W-1:0] accumulator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int P_W = A_W + B_W;

  // Widen an exact product to the accumulator width using the beat's own mode.
  function automatic logic [ACC_W-1:0] ext_prod(input logic [P_W-1:0] p, input logic sgn);
    logic [ACC_W-1:0] r;
    r = '0;
    r[P_W-1:0] = p;
    if (sgn && p[P_W-1]) begin
      for (int i = P_W; i < ACC_W; i++) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Overflow rule: carry out for unsigned beats, sign overflow for signed beats.
  function automatic logic add_ovf(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y,
                                   input logic [ACC_W-1:0] s, input logic carry,
                                   input logic sgn);
    logic sovf;
    sovf = (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
    return sgn ? sovf : carry;
  endfunction

`ifdef MAC_SAT_EN
  // On overflow clamp to the extreme in the direction of the running sum.
  function automatic logic [ACC_W-1:0] sat_sum(input logic [ACC_W-1:0] s, input logic ovf,
                                               input logic sgn, input logic neg);
    logic [ACC_W-1:0] r;
    r = s;
    if (ovf) begin
      if (!sgn)     r = '1;
      else if (neg) r = {1'b1, {(ACC_W-1){1'b0}}};
      else          r = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction
`endif

  logic                    stall;
  logic                    advance;
  logic                    accept;
  logic                    rdy_q, rdy_d;

  logic                    vld_p0_q, vld_p0_d;
  logic signed [A_W:0]     a_p0_q, a_p0_d;
  logic signed [B_W:0]     b_p0_q, b_p0_d;
  logic                    last_p0_q, last_p0_d;
  logic                    sgn_p0_q, sgn_p0_d;

  logic [PIPE:1]           vld_pn_q, vld_pn_d;
  logic [PIPE:1]           last_pn_q, last_pn_d;
  logic [PIPE:1]           sgn_pn_q, sgn_pn_d;
  logic [P_W-1:0]          prod_pn_q [1:PIPE];
  logic [P_W-1:0]          prod_pn_d [1:PIPE];
  logic signed [P_W-1:0]   prod_w;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    flag_q, flag_d;
  logic                    out_valid_q, out_valid_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic                    out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0]        prod_ext;
  logic [ACC_W:0]          sum_x;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        acc_new;
  logic                    beat_ovf;

  assign stall       = out_valid_q & ~out_ready;
  assign advance     = ~stall;
  assign in_ready    = rdy_q & ~stall & ~clear;
  assign accept      = in_valid & in_ready;
  assign accumulator = acc_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;

  // Operands were extended by mode at capture, so the low P_W bits are the exact product.
  assign prod_w = P_W'(a_p0_q) * P_W'(b_p0_q);

  // Datapath stages: p0 operand capture, p1..pPIPE multiplier registers.
  always_comb begin
    a_p0_d    = a_p0_q;
    b_p0_d    = b_p0_q;
    last_p0_d = last_p0_q;
    sgn_p0_d  = sgn_p0_q;
    prod_pn_d = prod_pn_q;
    last_pn_d = last_pn_q;
    sgn_pn_d  = sgn_pn_q;
    if (advance) begin
      a_p0_d       = signed_mode ? {in_a[A_W-1], in_a} : {1'b0, in_a};
      b_p0_d       = signed_mode ? {in_b[B_W-1], in_b} : {1'b0, in_b};
      last_p0_d    = in_last;
      sgn_p0_d     = signed_mode;
      prod_pn_d[1] = prod_w;
      last_pn_d[1] = last_p0_q;
      sgn_pn_d[1]  = sgn_p0_q;
      for (int k = 2; k <= PIPE; k++) begin
        prod_pn_d[k] = prod_pn_q[k-1];
        last_pn_d[k] = last_pn_q[k-1];
        sgn_pn_d[k]  = sgn_pn_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    a_p0_q    <= a_p0_d;
    b_p0_q    <= b_p0_d;
    last_p0_q <= last_p0_d;
    sgn_p0_q  <= sgn_p0_d;
    prod_pn_q <= prod_pn_d;
    last_pn_q <= last_pn_d;
    sgn_pn_q  <= sgn_pn_d;
  end

  // Accumulate stage: consumes the beat leaving the last multiplier register.
  always_comb begin
    prod_ext = ext_prod(prod_pn_q[PIPE], sgn_pn_q[PIPE]);
    sum_x    = {1'b0, acc_q} + {1'b0, prod_ext};
    sum      = sum_x[ACC_W-1:0];
    beat_ovf = add_ovf(acc_q, prod_ext, sum, sum_x[ACC_W], sgn_pn_q[PIPE]);
`ifdef MAC_SAT_EN
    acc_new  = sat_sum(sum, beat_ovf, sgn_pn_q[PIPE], acc_q[ACC_W-1]);
`else
    acc_new  = sum;
`endif
  end

  always_comb begin
    rdy_d       = 1'b1;
    vld_p0_d    = vld_p0_q;
    vld_pn_d    = vld_pn_q;
    acc_d       = acc_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (clear) begin
      vld_p0_d = 1'b0;
      vld_pn_d = '0;
      acc_d    = '0;
      flag_d   = 1'b0;
    end else if (advance) begin
      vld_p0_d    = accept;
      vld_pn_d[1] = vld_p0_q;
      for (int k = 2; k <= PIPE; k++) vld_pn_d[k] = vld_pn_q[k-1];
      if (vld_pn_q[PIPE]) begin
        if (last_pn_q[PIPE]) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_new;
          out_ovf_d   = flag_q | beat_ovf;
          acc_d       = '0;
          flag_d      = 1'b0;
        end else begin
          acc_d  = acc_new;
          flag_d = flag_q | beat_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q       <= 1'b0;
      vld_p0_q    <= 1'b0;
      vld_pn_q    <= '0;
      acc_q       <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      rdy_q       <= rdy_d;
      vld_p0_q    <= vld_p0_d;
      vld_pn_q    <= vld_pn_d;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_pipe_param.sv
// Scoreboard bench for mac_pipe_param at 8x8 operands, 16-bit accumulator, two multiplier stages.
module tb_mac_pipe_param;

  localparam int A_W = 8, B_W = 8, ACC_W = 16, PIPE = 2;

  logic             clk = 1'b0;
  logic             reset, clear, signed_mode, in_valid, in_last, out_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] accumulator, out_data;

  logic [ACC_W:0]   exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  mac_pipe_param #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .accumulator(accumulator), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic sgn);
    int   t    = 0;
    logic took = 1'b0;
    in_a = a; in_b = b; in_last = last; signed_mode = sgn; in_valid = 1'b1;
    while (!took && t < 200) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!took) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no in_ready want accept of a=%0h b=%0h", a, b);
    end
  endtask

  task automatic expect_result(input logic ovf, input logic [15:0] data);
    exp_q.push_back({ovf, data});
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every handshake, and checks backpressure reaches in_ready.
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h want no result", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[15:0]));
        check("out_ovf", 32'(out_ovf), 32'(e[16]));
      end
    end
    if (reset && out_valid && !out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
  end

  initial begin
    int cnt;
    reset = 1'b0; clear = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_accumulator", 32'(accumulator), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned frame and result latency
    expect_result(1'b0, 16'd98);
    send(8'd3, 8'd4, 1'b0, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    send(8'd7, 8'd8, 1'b1, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", 32'(cnt), 32'(PIPE + 1));
    drain("drain_unsigned");

    // Signed frame: -15 + 14 = -1
    expect_result(1'b0, 16'hFFFF);
    send(8'hFD, 8'd5, 1'b0, 1'b1);
    send(8'hFE, 8'hF9, 1'b1, 1'b1);
    drain("drain_signed");

    // Streaming with a 5-cycle backpressure window
    fork
      begin
        expect_result(1'b0, 16'd14);
        send(8'd1, 8'd2, 1'b0, 1'b0);
        send(8'd3, 8'd4, 1'b1, 1'b0);
        expect_result(1'b0, 16'd30);
        send(8'd5, 8'd6, 1'b1, 1'b0);
        expect_result(1'b0, 16'd106);
        send(8'd10, 8'd10, 1'b0, 1'b0);
        send(8'd2, 8'd3, 1'b1, 1'b0);
        expect_result(1'b0, 16'd49);
        send(8'd7, 8'd7, 1'b1, 1'b0);
        expect_result(1'b0, 16'd201);
        send(8'd100, 8'd2, 1'b0, 1'b0);
        send(8'd1, 8'd1, 1'b1, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");

    // Clear after two accumulated beats, then clear of an in-flight last beat
    send(8'd9, 8'd9, 1'b0, 1'b0);
    send(8'd1, 8'd1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("acc_before_clear", 32'(accumulator), 32'd82);
    clear = 1'b1;
    #1;
    check("in_ready_clear", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    check("acc_after_clear", 32'(accumulator), 32'd0);
    check("no_out_after_clear", 32'(out_valid), 32'd0);
    send(8'd3, 8'd3, 1'b1, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("acc_inflight_clear", 32'(accumulator), 32'd0);
    check("no_out_inflight_clear", 32'(out_valid), 32'd0);
    expect_result(1'b0, 16'd4);
    send(8'd2, 8'd2, 1'b1, 1'b0);
    drain("drain_after_clear");

    // Unsigned overflow: 2 * 65025 = 130050
`ifdef MAC_SAT_EN
    expect_result(1'b1, 16'hFFFF);
`else
    expect_result(1'b1, 16'hFC02);
`endif
    send(8'd255, 8'd255, 1'b0, 1'b0);
    send(8'd255, 8'd255, 1'b1, 1'b0);
    drain("drain_overflow");

    // Reset mid-frame with a result pending
    out_ready = 1'b0;
    send(8'd5, 8'd5, 1'b1, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("pending_before_reset", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_ovf", 32'(out_ovf), 32'd0);
    check("midrst_accumulator", 32'(accumulator), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    out_ready = 1'b1;
    expect_result(1'b0, 16'd81);
    send(8'd9, 8'd9, 1'b1, 1'b0);
    drain("drain_after_reset");
    repeat (8) @(posedge clk);
    #1;
    check("no_extra_results", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
